// File: rtl/obstacle_field_ctrl.sv
// Ball-and-obstacle game field controller: one motion and collision update per accepted video frame.
// Latency: collision / finish_line_reached pulse is registered exactly 6 cycles after the accepted frame_tick.
// Backpressure: none; frame_tick outside IDLE is dropped, HOLD waits for reset_player.
// Optional feature macro: OBS_SPAWN_GRACE_EN (ignore collisions for the first 32 frames after a spawn).
module obstacle_field_ctrl #(
    parameter int BALL_SIZE = 4,
    parameter int OBS_SIZE  = 8,
    parameter int FINISH_X  = 620,
    parameter int START_X   = 20,
    parameter int START_Y   = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_right,
    input  logic [1:0]  speed,
    input  logic [1:0]  obstacle_count,
    input  logic        reset_player,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [29:0] obs_y,
    output logic [2:0]  obs_active,
    output logic        collision,
    output logic        finish_line_reached
);

    localparam logic [9:0] BALL_Y_MIN = 10'(BALL_SIZE);
    localparam logic [9:0] BALL_Y_MAX = 10'(479 - BALL_SIZE);
    localparam logic [9:0] BALL_X_MAX = 10'(639 - BALL_SIZE);
    localparam logic [9:0] OBS_Y_MIN  = 10'(OBS_SIZE);
    localparam logic [9:0] OBS_Y_MAX  = 10'(479 - OBS_SIZE);
    localparam logic [9:0] HIT_DIST   = 10'(BALL_SIZE + OBS_SIZE);
    localparam logic [9:0] FINISH_POS = 10'(FINISH_X);
    localparam logic [9:0] OBS0_X     = 10'(160 * 1);
    localparam logic [9:0] OBS1_X     = 10'(160 * 2);
    localparam logic [9:0] OBS2_X     = 10'(160 * 3);

    typedef enum logic [2:0] {
        IDLE,
        BALL_UPD,
        OBS_UPD,
        CHECK,
        REPORT,
        HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [9:0] oy     [3];
    logic [9:0] oy_nxt [3];
    logic [2:0] od;            // bit i high: obstacle i moving down (increasing y)
    logic [2:0] od_nxt;
    logic [9:0] step;
    logic [9:0] ball_x_nxt;
    logic [9:0] ball_y_nxt;
    logic [2:0] act_q;         // active mask frozen at OBS_UPD for the CHECK pass
    logic [1:0] chk_cnt;
    logic [9:0] chk_x;
    logic [9:0] chk_y;
    logic       chk_act;
    logic [9:0] dx;
    logic [9:0] dy;
    logic       hit_now;
    logic       hit_flag;
    logic       hit_eff;
    logic       finish_now;
    logic       accept;
    logic       ball_en;
    logic       obs_en;
    logic       chk_en;
    logic       rep_en;

    assign obs_y      = {oy[2], oy[1], oy[0]};
    assign step       = {8'd0, speed};
    assign finish_now = (ball_x >= FINISH_POS);

    // Active-obstacle mask follows obstacle_count directly.
    always_comb begin
        obs_active = 3'b000;
        case (obstacle_count)
            2'd1:    obs_active = 3'b001;
            2'd2:    obs_active = 3'b011;
            2'd3:    obs_active = 3'b111;
            default: obs_active = 3'b000;
        endcase
    end

`ifdef OBS_SPAWN_GRACE_EN
    logic [5:0] grace_cnt;

    // Count accepted frames since (re)spawn; saturates at 33, the first frame allowed to collide.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            grace_cnt <= 6'd0;
        end else if (accept && (grace_cnt != 6'd33)) begin
            grace_cnt <= grace_cnt + 6'd1;
        end
    end

    assign hit_eff = hit_flag && (grace_cnt == 6'd33);
`else
    assign hit_eff = hit_flag;
`endif

    // State register; a respawn request returns to IDLE like a reset.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state update strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ball_en   = 1'b0;
        obs_en    = 1'b0;
        chk_en    = 1'b0;
        rep_en    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    accept    = 1'b1;
                    state_nxt = BALL_UPD;
                end
            end
            BALL_UPD: begin
                ball_en   = 1'b1;
                state_nxt = OBS_UPD;
            end
            OBS_UPD: begin
                obs_en    = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                chk_en = 1'b1;
                if (chk_cnt == 2'd2) begin
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                rep_en    = 1'b1;
                state_nxt = (hit_eff || finish_now) ? HOLD : IDLE;
            end
            HOLD: begin
                state_nxt = HOLD;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Ball step with clamping; opposing vertical requests cancel.
    always_comb begin
        ball_y_nxt = ball_y;
        ball_x_nxt = ball_x;
        if (move_up && !move_down) begin
            ball_y_nxt = (ball_y < BALL_Y_MIN + 10'd2) ? BALL_Y_MIN : ball_y - 10'd2;
        end else if (move_down && !move_up) begin
            ball_y_nxt = (ball_y + 10'd2 > BALL_Y_MAX) ? BALL_Y_MAX : ball_y + 10'd2;
        end
        if (move_right) begin
            ball_x_nxt = (ball_x + 10'd2 > BALL_X_MAX) ? BALL_X_MAX : ball_x + 10'd2;
        end
    end

    // Obstacle vertical step; a step that would cross a bound clamps to it and bounces.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            oy_nxt[i] = oy[i];
            od_nxt[i] = od[i];
            if (obs_active[i]) begin
                if (od[i]) begin
                    if (oy[i] + step > OBS_Y_MAX) begin
                        oy_nxt[i] = OBS_Y_MAX;
                        od_nxt[i] = 1'b0;
                    end else begin
                        oy_nxt[i] = oy[i] + step;
                    end
                end else begin
                    if (oy[i] < OBS_Y_MIN + step) begin
                        oy_nxt[i] = OBS_Y_MIN;
                        od_nxt[i] = 1'b1;
                    end else begin
                        oy_nxt[i] = oy[i] - step;
                    end
                end
            end
        end
    end

    // Overlap test for the obstacle selected by the CHECK counter.
    always_comb begin
        chk_x   = OBS0_X;
        chk_y   = oy[0];
        chk_act = act_q[0];
        case (chk_cnt)
            2'd1: begin
                chk_x   = OBS1_X;
                chk_y   = oy[1];
                chk_act = act_q[1];
            end
            2'd2: begin
                chk_x   = OBS2_X;
                chk_y   = oy[2];
                chk_act = act_q[2];
            end
            default: begin
                chk_x   = OBS0_X;
                chk_y   = oy[0];
                chk_act = act_q[0];
            end
        endcase
        dx      = (ball_x >= chk_x) ? ball_x - chk_x : chk_x - ball_x;
        dy      = (ball_y >= chk_y) ? ball_y - chk_y : chk_y - ball_y;
        hit_now = chk_act && (dx < HIT_DIST) && (dy < HIT_DIST);
    end

    // Ball position register.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            ball_x <= 10'(START_X);
            ball_y <= 10'(START_Y);
        end else if (ball_en) begin
            ball_x <= ball_x_nxt;
            ball_y <= ball_y_nxt;
        end
    end

    // Obstacle positions, directions and the active mask used by CHECK.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            oy[0] <= 10'd120;
            oy[1] <= 10'd240;
            oy[2] <= 10'd360;
            od    <= 3'b101;
            act_q <= 3'b000;
        end else if (obs_en) begin
            oy[0] <= oy_nxt[0];
            oy[1] <= oy_nxt[1];
            oy[2] <= oy_nxt[2];
            od    <= od_nxt;
            act_q <= obs_active;
        end
    end

    // CHECK counter and sticky hit flag, both cleared at the start of every frame.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            chk_cnt  <= 2'd0;
            hit_flag <= 1'b0;
        end else if (accept) begin
            chk_cnt  <= 2'd0;
            hit_flag <= 1'b0;
        end else if (chk_en) begin
            chk_cnt  <= chk_cnt + 2'd1;
            hit_flag <= hit_flag | hit_now;
        end
    end

    // One-cycle event pulses; collision wins over finish, respawn suppresses both.
    always_ff @(posedge clk) begin
        if (reset || reset_player) begin
            collision           <= 1'b0;
            finish_line_reached <= 1'b0;
        end else begin
            collision           <= rep_en && hit_eff;
            finish_line_reached <= rep_en && !hit_eff && finish_now;
        end
    end

endmodule

// File: tb/tb_obstacle_field_ctrl.sv
// Self-checking bench for obstacle_field_ctrl against a frame-level behavioural model.
// Latency: pulses expected exactly 6 cycles after the accepted frame_tick.
// Backpressure: none; all waits are fixed cycle counts plus a global timeout.
module tb_obstacle_field_ctrl;

    localparam int BS  = 4;
    localparam int OS  = 8;
    localparam int FIN = 620;
    localparam int SX  = 20;
    localparam int SY  = 240;
`ifdef OBS_SPAWN_GRACE_EN
    localparam bit GRACE = 1'b1;
`else
    localparam bit GRACE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        move_up;
    logic        move_down;
    logic        move_right;
    logic [1:0]  speed;
    logic [1:0]  obstacle_count;
    logic        reset_player;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [29:0] obs_y;
    logic [2:0]  obs_active;
    logic        collision;
    logic        finish_line_reached;

    int n_cmp = 0;
    int n_bad = 0;

    // frame-level model state
    int m_bx;
    int m_by;
    int m_oy [3];
    bit m_od [3];
    bit m_hold;
    int m_frames;

    always #5 clk = ~clk;

    obstacle_field_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .frame_tick          (frame_tick),
        .move_up             (move_up),
        .move_down           (move_down),
        .move_right          (move_right),
        .speed               (speed),
        .obstacle_count      (obstacle_count),
        .reset_player        (reset_player),
        .ball_x              (ball_x),
        .ball_y              (ball_y),
        .obs_y               (obs_y),
        .obs_active          (obs_active),
        .collision           (collision),
        .finish_line_reached (finish_line_reached)
    );

    task automatic model_respawn();
        m_bx     = SX;
        m_by     = SY;
        m_oy[0]  = 120;
        m_oy[1]  = 240;
        m_oy[2]  = 360;
        m_od[0]  = 1'b1;
        m_od[1]  = 1'b0;
        m_od[2]  = 1'b1;
        m_hold   = 1'b0;
        m_frames = 0;
    endtask

    // ev: 0 none, 1 collision, 2 finish
    task automatic model_frame(input bit up, input bit dn, input bit rt,
                               input int spd, input int cnt, output int ev);
        bit hit;
        int ddx;
        int ddy;
        ev = 0;
        if (!m_hold) begin
            m_frames++;
            if (up && !dn) m_by = m_by - 2;
            if (dn && !up) m_by = m_by + 2;
            if (rt)        m_bx = m_bx + 2;
            if (m_by < BS)        m_by = BS;
            if (m_by > 479 - BS)  m_by = 479 - BS;
            if (m_bx > 639 - BS)  m_bx = 639 - BS;
            for (int i = 0; i < cnt; i++) begin
                if (m_od[i]) begin
                    m_oy[i] = m_oy[i] + spd;
                    if (m_oy[i] > 479 - OS) begin m_oy[i] = 479 - OS; m_od[i] = 1'b0; end
                end else begin
                    m_oy[i] = m_oy[i] - spd;
                    if (m_oy[i] < OS) begin m_oy[i] = OS; m_od[i] = 1'b1; end
                end
            end
            hit = 1'b0;
            for (int i = 0; i < cnt; i++) begin
                ddx = m_bx - 160 * (i + 1);
                ddy = m_by - m_oy[i];
                if (ddx < 0) ddx = -ddx;
                if (ddy < 0) ddy = -ddy;
                if (ddx < BS + OS && ddy < BS + OS) hit = 1'b1;
            end
            if (GRACE && m_frames <= 32) hit = 1'b0;
            if (hit) begin
                ev = 1;
                m_hold = 1'b1;
            end else if (m_bx >= FIN) begin
                ev = 2;
                m_hold = 1'b1;
            end
        end
    endtask

    function automatic logic [29:0] model_obs_y();
        return {10'(m_oy[2]), 10'(m_oy[1]), 10'(m_oy[0])};
    endfunction

    // One accepted frame_tick; records pulse levels for the 8 cycles after acceptance.
    task automatic run_frame(input bit up, input bit dn, input bit rt, input int spd, input int cnt,
                             output logic [8:0] cm, output logic [8:0] fm,
                             output logic [8:0] ecm, output logic [8:0] efm);
        int ev;
        move_up        = up;
        move_down      = dn;
        move_right     = rt;
        speed          = 2'(spd);
        obstacle_count = 2'(cnt);
        frame_tick     = 1'b1;
        @(posedge clk); #1;
        frame_tick     = 1'b0;
        model_frame(up, dn, rt, spd, cnt, ev);
        cm = '0;
        fm = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            cm[k] = collision;
            fm[k] = finish_line_reached;
        end
        ecm = (ev == 1) ? 9'b001000000 : 9'b000000000;
        efm = (ev == 2) ? 9'b001000000 : 9'b000000000;
    endtask

    task automatic respawn();
        reset_player = 1'b1;
        @(posedge clk); #1;
        reset_player = 1'b0;
        model_respawn();
    endtask

    // Moves the ball with no active obstacles and frozen field.
    task automatic travel(input int frames, input bit up, input bit rt);
        logic [8:0] cm, fm, ecm, efm;
        for (int f = 0; f < frames; f++) begin
            run_frame(up, 1'b0, rt, 0, 0, cm, fm, ecm, efm);
        end
    endtask

    task automatic test_reset();
        logic [2:0] exp_act;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_respawn();
        n_cmp++; if (ball_x !== 10'd20) begin n_bad++; $display("FAIL reset_ball_x: got %0d want 20", ball_x); end
        n_cmp++; if (ball_y !== 10'd240) begin n_bad++; $display("FAIL reset_ball_y: got %0d want 240", ball_y); end
        n_cmp++; if (obs_y !== {10'd360, 10'd240, 10'd120}) begin n_bad++; $display("FAIL reset_obs_y: got %h want %h", obs_y, {10'd360, 10'd240, 10'd120}); end
        n_cmp++; if (collision !== 1'b0 || finish_line_reached !== 1'b0) begin n_bad++; $display("FAIL reset_pulses: got %b%b want 00", collision, finish_line_reached); end
        for (int c = 0; c < 4; c++) begin
            obstacle_count = 2'(c);
            #1;
            exp_act = '0;
            for (int i = 0; i < 3; i++) if (i < c) exp_act[i] = 1'b1;
            n_cmp++; if (obs_active !== exp_act) begin n_bad++; $display("FAIL obs_active cnt=%0d: got %b want %b", c, obs_active, exp_act); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_first_frame();
        logic [8:0] cm, fm, ecm, efm;
        run_frame(1'b0, 1'b0, 1'b1, 1, 1, cm, fm, ecm, efm);
        n_cmp++; if (ball_x !== 10'd22 || ball_y !== 10'd240) begin n_bad++; $display("FAIL first_ball: got (%0d,%0d) want (22,240)", ball_x, ball_y); end
        n_cmp++; if (obs_y[9:0] !== 10'd121) begin n_bad++; $display("FAIL first_obs0: got %0d want 121", obs_y[9:0]); end
        n_cmp++; if (cm !== 9'd0 || fm !== 9'd0) begin n_bad++; $display("FAIL first_pulses: got %b/%b want none", cm, fm); end
        run_frame(1'b0, 1'b0, 1'b1, 1, 1, cm, fm, ecm, efm);
        n_cmp++; if (ball_x !== 10'(m_bx) || obs_y !== model_obs_y()) begin n_bad++; $display("FAIL second_frame: got x=%0d obs=%h want x=%0d obs=%h", ball_x, obs_y, m_bx, model_obs_y()); end
    endtask

    // frame_tick held through every non-IDLE state must produce only one frame of motion.
    task automatic test_dropped_tick();
        int ev;
        move_up = 1'b0; move_down = 1'b1; move_right = 1'b1; speed = 2'd2; obstacle_count = 2'd3;
        frame_tick = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        frame_tick = 1'b0;
        model_frame(1'b0, 1'b1, 1'b1, 2, 3, ev);
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (ball_x !== 10'(m_bx) || ball_y !== 10'(m_by)) begin n_bad++; $display("FAIL dropped_tick_ball: got (%0d,%0d) want (%0d,%0d)", ball_x, ball_y, m_bx, m_by); end
        n_cmp++; if (obs_y !== model_obs_y()) begin n_bad++; $display("FAIL dropped_tick_obs: got %h want %h", obs_y, model_obs_y()); end
    endtask

    task automatic test_obs_bounce();
        logic [8:0] cm, fm, ecm, efm;
        respawn();
        for (int f = 0; f < 117; f++) run_frame(1'b0, 1'b0, 1'b0, 3, 1, cm, fm, ecm, efm);
        n_cmp++; if (obs_y[9:0] !== 10'd471) begin n_bad++; $display("FAIL bounce_reach: got %0d want 471", obs_y[9:0]); end
        run_frame(1'b0, 1'b0, 1'b0, 3, 1, cm, fm, ecm, efm);
        n_cmp++; if (obs_y[9:0] !== 10'd471) begin n_bad++; $display("FAIL bounce_clamp: got %0d want 471", obs_y[9:0]); end
        run_frame(1'b0, 1'b0, 1'b0, 3, 1, cm, fm, ecm, efm);
        n_cmp++; if (obs_y[9:0] !== 10'd468) begin n_bad++; $display("FAIL bounce_reverse: got %0d want 468", obs_y[9:0]); end
        n_cmp++; if (obs_y[29:10] !== {10'd360, 10'd240}) begin n_bad++; $display("FAIL bounce_inactive_hold: got %h want %h", obs_y[29:10], {10'd360, 10'd240}); end
    endtask

    task automatic test_collision_hold();
        logic [8:0] cm, fm, ecm, efm;
        respawn();
        travel(60, 1'b1, 1'b1);
        travel(8, 1'b0, 1'b1);
        n_cmp++; if (ball_x !== 10'd156 || ball_y !== 10'd120) begin n_bad++; $display("FAIL coll_setup: got (%0d,%0d) want (156,120)", ball_x, ball_y); end
        run_frame(1'b0, 1'b0, 1'b0, 0, 1, cm, fm, ecm, efm);
        n_cmp++; if (cm !== ecm) begin n_bad++; $display("FAIL coll_pulse: got %b want %b", cm, ecm); end
        n_cmp++; if (fm !== 9'd0) begin n_bad++; $display("FAIL coll_no_finish: got %b want 0", fm); end
        for (int f = 0; f < 2; f++) begin
            run_frame(1'b1, 1'b0, 1'b1, 3, 3, cm, fm, ecm, efm);
            n_cmp++; if (ball_x !== 10'd156 || ball_y !== 10'd120 || obs_y !== model_obs_y()) begin n_bad++; $display("FAIL hold_motion: got (%0d,%0d) %h want (156,120) %h", ball_x, ball_y, obs_y, model_obs_y()); end
            n_cmp++; if (cm !== 9'd0 || fm !== 9'd0) begin n_bad++; $display("FAIL hold_pulses: got %b/%b want none", cm, fm); end
        end
        respawn();
        n_cmp++; if (ball_x !== 10'd20 || ball_y !== 10'd240) begin n_bad++; $display("FAIL hold_respawn: got (%0d,%0d) want (20,240)", ball_x, ball_y); end
    endtask

    // Respawn while CHECK holds a pending hit; a tick arriving during CHECK is ignored.
    task automatic test_respawn_in_check();
        logic [8:0] cm;
        respawn();
        travel(60, 1'b1, 1'b1);
        travel(8, 1'b0, 1'b1);
        move_up = 1'b0; move_down = 1'b0; move_right = 1'b0; speed = 2'd0; obstacle_count = 2'd1;
        frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0; reset_player = 1'b1;
        @(posedge clk); #1; reset_player = 1'b0;
        model_respawn();
        cm = '0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            cm[k] = collision | finish_line_reached;
        end
        n_cmp++; if (cm !== 9'd0) begin n_bad++; $display("FAIL check_respawn_pulse: got %b want none", cm); end
        n_cmp++; if (ball_x !== 10'd20 || ball_y !== 10'd240) begin n_bad++; $display("FAIL check_respawn_ball: got (%0d,%0d) want (20,240)", ball_x, ball_y); end
        n_cmp++; if (obs_y !== {10'd360, 10'd240, 10'd120}) begin n_bad++; $display("FAIL check_respawn_obs: got %h want %h", obs_y, {10'd360, 10'd240, 10'd120}); end
    endtask

    // Respawn landing on the REPORT cycle suppresses the due collision pulse.
    task automatic test_respawn_in_report();
        logic [3:0] cm;
        respawn();
        travel(60, 1'b1, 1'b1);
        travel(8, 1'b0, 1'b1);
        move_up = 1'b0; move_down = 1'b0; move_right = 1'b0; speed = 2'd0; obstacle_count = 2'd1;
        frame_tick = 1'b1;
        @(posedge clk); #1; frame_tick = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset_player = 1'b1;
        @(posedge clk); #1; reset_player = 1'b0;
        model_respawn();
        cm[0] = collision;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            cm[k] = collision;
        end
        n_cmp++; if (cm !== 4'd0) begin n_bad++; $display("FAIL report_respawn_pulse: got %b want 0000", cm); end
        n_cmp++; if (ball_x !== 10'd20 || ball_y !== 10'd240) begin n_bad++; $display("FAIL report_respawn_ball: got (%0d,%0d) want (20,240)", ball_x, ball_y); end
    endtask

    task automatic test_finish();
        logic [8:0] cm, fm, ecm, efm;
        respawn();
        travel(299, 1'b0, 1'b1);
        n_cmp++; if (ball_x !== 10'd618) begin n_bad++; $display("FAIL finish_setup: got %0d want 618", ball_x); end
        run_frame(1'b0, 1'b0, 1'b1, 0, 0, cm, fm, ecm, efm);
        n_cmp++; if (fm !== 9'b001000000) begin n_bad++; $display("FAIL finish_pulse: got %b want %b", fm, 9'b001000000); end
        n_cmp++; if (cm !== 9'd0) begin n_bad++; $display("FAIL finish_no_coll: got %b want 0", cm); end
        run_frame(1'b0, 1'b0, 1'b1, 0, 0, cm, fm, ecm, efm);
        n_cmp++; if (ball_x !== 10'd620 || fm !== 9'd0) begin n_bad++; $display("FAIL finish_hold: got x=%0d fm=%b want x=620 none", ball_x, fm); end
        respawn();
    endtask

    task automatic test_random();
        logic [8:0] cm, fm, ecm, efm;
        bit up, dn, rt;
        int spd, cnt;
        respawn();
        for (int f = 0; f < 220; f++) begin
            if (m_hold || $urandom_range(0, 29) == 0) respawn();
            up  = 1'($urandom_range(0, 1));
            dn  = 1'($urandom_range(0, 1));
            rt  = ($urandom_range(0, 3) != 0);
            spd = $urandom_range(0, 3);
            cnt = $urandom_range(0, 3);
            run_frame(up, dn, rt, spd, cnt, cm, fm, ecm, efm);
            n_cmp++; if (cm !== ecm) begin n_bad++; $display("FAIL rnd_collision f%0d: got %b want %b", f, cm, ecm); end
            n_cmp++; if (fm !== efm) begin n_bad++; $display("FAIL rnd_finish f%0d: got %b want %b", f, fm, efm); end
            n_cmp++; if (ball_x !== 10'(m_bx) || ball_y !== 10'(m_by)) begin n_bad++; $display("FAIL rnd_ball f%0d: got (%0d,%0d) want (%0d,%0d)", f, ball_x, ball_y, m_bx, m_by); end
            n_cmp++; if (obs_y !== model_obs_y()) begin n_bad++; $display("FAIL rnd_obs f%0d: got %h want %h", f, obs_y, model_obs_y()); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        frame_tick     = 1'b0;
        move_up        = 1'b0;
        move_down      = 1'b0;
        move_right     = 1'b0;
        speed          = 2'd0;
        obstacle_count = 2'd0;
        reset_player   = 1'b0;
        test_reset();
        test_first_frame();
        test_dropped_tick();
        test_obs_bounce();
        test_collision_hold();
        test_respawn_in_check();
        test_respawn_in_report();
        test_finish();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
